// File: rtl/serial_parity_frame_checker_if.sv
// rtl/serial_parity_frame_checker_if.sv - lane data, strobe and status bundle for the frame parity checker
interface serial_parity_frame_checker_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] x;
    logic                valid;
    logic                sync;
    logic                odd_mode;
    logic [CHANNELS-1:0] even_odd;
    logic [CHANNELS-1:0] parity_err;
    logic                frame_done;
    logic [15:0]         err_count;

    modport master (
        output x, valid, sync, odd_mode,
        input  even_odd, parity_err, frame_done, err_count
    );

    modport slave (
        input  x, valid, sync, odd_mode,
        output even_odd, parity_err, frame_done, err_count
    );
endinterface

// File: rtl/serial_parity_frame_checker.sv
// rtl/serial_parity_frame_checker.sv - per-lane frame parity checker; PARITY_ERR_COUNT_EN builds the saturating error-frame counter
module serial_parity_frame_checker #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8
) (
    input logic clock,
    input logic reset_n,
    serial_parity_frame_checker_if.slave bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    // Counter value on the edge that consumes the final data bit.
    localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [CHANNELS-1:0] r_acc;
    logic                r_mode;
    logic [CHANNELS-1:0] r_parity_err;
    logic                r_frame_done;

    logic [CHANNELS-1:0] w_new_err;
    logic                w_parity_fire;

    // Result of the check if the current lane bits are the parity bits.
    assign w_new_err     = r_acc ^ bus.x ^ {CHANNELS{r_mode}};
    assign w_parity_fire = bus.valid & ~bus.sync & (r_state == S_PARITY);

    // Frame FSM: bit counting, running parity, mode latch and check result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mode       <= 1'b0;
            r_parity_err <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.sync) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else if (bus.valid) begin
                case (r_state)
                    S_IDLE: begin
                        r_acc   <= bus.x;
                        r_cnt   <= CW'(1);
                        r_mode  <= bus.odd_mode;
                        r_state <= (FRAME_LEN == 1) ? S_PARITY : S_DATA;
                    end
                    S_DATA: begin
                        r_acc <= r_acc ^ bus.x;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST_DATA) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity_err <= w_new_err;
                        r_frame_done <= 1'b1;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end
                    default: begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [15:0] r_err_count;

    // Saturating count of frames where at least one lane failed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_count <= 16'h0000;
        end else if (w_parity_fire && (|w_new_err) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_parity_fire;
    assign bus.err_count = 16'h0000;
`endif

    assign bus.even_odd   = r_acc;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// tb/tb_serial_parity_frame_checker.sv - randomized self-checking bench against a frame-level parity model
module tb_serial_parity_frame_checker;
    localparam int C  = 4;
    localparam int FL = 8;
`ifdef PARITY_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    serial_parity_frame_checker_if #(.CHANNELS(C)) bus ();

    serial_parity_frame_checker #(.CHANNELS(C), .FRAME_LEN(FL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: bits seen so far in the frame and how many ones per lane.
    int         m_k;
    int         m_ones [C];
    bit         m_mode;
    bit [C-1:0] m_err;
    bit         m_done;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic s, input logic v,
                         input logic [C-1:0] xv, input logic om);
        m_done = 1'b0;
        if (!rst) begin
            m_k = 0; m_err = '0; m_cnt = 0;
            for (int i = 0; i < C; i++) m_ones[i] = 0;
        end else if (s) begin
            m_k = 0;
            for (int i = 0; i < C; i++) m_ones[i] = 0;
        end else if (v) begin
            if (m_k < FL) begin
                if (m_k == 0) m_mode = om;
                for (int i = 0; i < C; i++) m_ones[i] += int'(xv[i]);
                m_k++;
            end else begin
                for (int i = 0; i < C; i++)
                    m_err[i] = ((m_ones[i] + int'(xv[i]) + int'(m_mode)) % 2) == 1;
                m_done = 1'b1;
                if (CNT_EN && m_err != '0 && m_cnt < 65535) m_cnt++;
                m_k = 0;
                for (int i = 0; i < C; i++) m_ones[i] = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic s, input logic v,
                        input logic [C-1:0] xv, input logic om);
        logic [C-1:0] exp_eo;
        @(negedge clock);
        reset_n = rst; bus.sync = s; bus.valid = v; bus.x = xv; bus.odd_mode = om;
        @(posedge clock);
        model(rst, s, v, xv, om);
        #1;
        for (int i = 0; i < C; i++) exp_eo[i] = (m_ones[i] % 2) == 1;
        check("even_odd",   32'(bus.even_odd),   32'(exp_eo));
        check("parity_err", 32'(bus.parity_err), 32'(m_err));
        check("frame_done", 32'(bus.frame_done), 32'(m_done));
        check("err_count",  32'(bus.err_count),  32'(m_cnt));
    endtask

    task automatic rand_frame(input logic om);
        for (int b = 0; b <= FL; b++) step(1'b1, 1'b0, 1'b1, C'($urandom), om);
    endtask

    initial begin
        logic [7:0] pat;
        reset_n = 1'b0; bus.sync = 1'b0; bus.valid = 1'b0; bus.x = '0; bus.odd_mode = 1'b0;
        m_mode = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("reset_eo", 32'(bus.even_odd), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Lane 0 data 1011_0010, correct even parity.
        pat = 8'b1011_0010;
        for (int b = 0; b < FL; b++) step(1'b1, 1'b0, 1'b1, {3'b000, pat[7-b]}, 1'b0);
        check("t1_eo_before_parity", 32'(bus.even_odd[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        check("t1_done", 32'(bus.frame_done), 32'd1);
        check("t1_err0", 32'(bus.parity_err[0]), 32'd0);

        // Same data, wrong parity bit.
        for (int b = 0; b < FL; b++) step(1'b1, 1'b0, 1'b1, {3'b000, pat[7-b]}, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
        check("t2_err0", 32'(bus.parity_err[0]), 32'd1);
        check("t2_cnt", 32'(bus.err_count), CNT_EN ? 32'd1 : 32'd0);

        // Odd mode latched at start, toggled off mid-frame.
        for (int b = 0; b < FL; b++) step(1'b1, 1'b0, 1'b1, 4'b0000, (b == 0));
        step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
        check("t3_err", 32'(bus.parity_err), 32'd0);

        // Valid every other cycle.
        for (int i = 0; i < 2 * (FL + 1); i++)
            step(1'b1, 1'b0, (i % 2) == 0, C'($urandom), 1'b0);

        // Abort after 5 data bits, then a clean frame.
        for (int b = 0; b < 5; b++) step(1'b1, 1'b0, 1'b1, C'($urandom), 1'b1);
        step(1'b1, 1'b1, 1'b1, C'($urandom), 1'b0);
        rand_frame(1'b1);

        // Reset after 3 data bits, then a normal frame.
        for (int b = 0; b < 3; b++) step(1'b1, 1'b0, 1'b1, C'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b1, C'($urandom), 1'b0);
        check("t6_rst_err", 32'(bus.parity_err), 32'd0);
        rand_frame(1'b0);

        // Random traffic with occasional sync and reset.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7), C'($urandom), 1'($urandom));

        // Saturation: preload near the top, then push error frames.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
`ifdef PARITY_ERR_COUNT_EN
        @(negedge clock);
        force dut.r_err_count = 16'hFFF0;
        @(negedge clock);
        release dut.r_err_count;
        m_cnt = 32'hFFF0;
`endif
        for (int f = 0; f < 24; f++) begin
            for (int b = 0; b < FL; b++) step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
            step(1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
        end
        check("sat_cnt", 32'(bus.err_count), CNT_EN ? 32'hFFFF : 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
